// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared codes for the decode-stage hazard scoreboard:
//                producer kinds, forwarding-select codes, retirement age.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Producer kinds carried by each in-flight destination register.
  localparam logic [1:0] KIND_ALU    = 2'd0;
  localparam logic [1:0] KIND_LOAD   = 2'd1;
  localparam logic [1:0] KIND_MULDIV = 2'd2;

  // Operand source selects presented to the D/X operand muxes.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_X  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Age at which a producer's value is in the register file.
  localparam logic [2:0] AGE_RETIRE = 3'd4;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
//  Module      : sb_entry
//  Description : One scoreboard slot: valid/age/kind of the newest in-flight
//                producer of a single architectural register.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_entry
  import pipe_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       i_alloc,
  input  logic [1:0] i_kind,
  input  logic       i_hold,
  output logic       o_valid,
  output logic [2:0] o_age,
  output logic [1:0] o_kind
);

  logic       r_valid;
  logic [2:0] r_age;
  logic [1:0] r_kind;

  // Allocate on issue (newest producer wins), otherwise age until retired.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_age   <= 3'd0;
      r_kind  <= KIND_ALU;
    end else if (i_alloc) begin
      r_valid <= 1'b1;
      r_age   <= 3'd1;
      r_kind  <= i_kind;
    end else if (!i_hold && r_valid) begin
      if (r_age == (AGE_RETIRE - 3'd1)) begin
        r_valid <= 1'b0;
        r_age   <= 3'd0;
      end else begin
        r_age   <= r_age + 3'd1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_age   = r_age;
  assign o_kind  = r_kind;

endmodule : sb_entry
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_scoreboard
//  Description : Per-register hazard scoreboard beside the D stage. Tracks
//                in-flight destinations and produces stall, issue and
//                per-operand bypass selects combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 5,
  parameter bit BYPASS_EN = 1'b1
)
(
  input  logic                clock,
  input  logic                reset,
  input  logic                hold,
  input  logic                flush,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs_a,
  input  logic                id_use_a,
  input  logic [REG_W-1:0]    id_rs_b,
  input  logic                id_use_b,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_wr,
  input  logic [1:0]          id_kind,
  output logic                stall,
  output logic [1:0]          fwd_sel_a,
  output logic [1:0]          fwd_sel_b,
  output logic                issue,
  output logic [NUM_REGS-1:0] pending
);

  // Table is sized to the full index space so any rs value indexes safely.
  localparam int c_DEPTH = 1 << REG_W;

  logic [c_DEPTH-1:0] w_valid;
  logic [2:0]         w_age  [c_DEPTH];
  logic [1:0]         w_kind [c_DEPTH];
  logic               w_issue;
  logic [2:0]         w_look_a;
  logic [2:0]         w_look_b;

  // Returns {stall_term, fwd_sel} for one source operand.
  function automatic logic [2:0] f_lookup(
    input logic             use_op,
    input logic [REG_W-1:0] rs,
    input logic             ent_valid,
    input logic [2:0]       ent_age,
    input logic [1:0]       ent_kind
  );
    logic       stl;
    logic [1:0] sel;
    stl = 1'b0;
    sel = FWD_RF;
    if (use_op && (rs != '0) && ent_valid) begin
      if (BYPASS_EN) begin
        case (ent_age)
          3'd1: begin
            // A load result is not available until M: one bubble.
            if (ent_kind == KIND_LOAD) stl = 1'b1;
            else                       sel = FWD_X;
          end
          3'd2:    sel = FWD_M;
          3'd3:    sel = FWD_W;
          default: sel = FWD_RF;
        endcase
      end else if (ent_age < AGE_RETIRE) begin
        stl = 1'b1;
      end
    end
    return {stl, sel};
  endfunction

  generate
    for (genvar r = 0; r < c_DEPTH; r++) begin : g_entry
      if (r == 0 || r >= NUM_REGS) begin : g_none
        // r0 is hard-wired zero; indices past NUM_REGS do not exist.
        assign w_valid[r] = 1'b0;
        assign w_age[r]   = 3'd0;
        assign w_kind[r]  = KIND_ALU;
      end else begin : g_slot
        logic w_alloc;
        assign w_alloc = w_issue & id_wr & (id_rd == REG_W'(r));
        sb_entry u_entry (
          .clock   (clock),
          .reset   (reset),
          .i_alloc (w_alloc),
          .i_kind  (id_kind),
          .i_hold  (hold),
          .o_valid (w_valid[r]),
          .o_age   (w_age[r]),
          .o_kind  (w_kind[r])
        );
      end
    end
  endgenerate

  // Look up both source operands against the current table.
  always_comb begin
    w_look_a = f_lookup(id_use_a, id_rs_a, w_valid[id_rs_a], w_age[id_rs_a], w_kind[id_rs_a]);
    w_look_b = f_lookup(id_use_b, id_rs_b, w_valid[id_rs_b], w_age[id_rs_b], w_kind[id_rs_b]);
  end

  // Flush only blocks issue; it does not mask the stall request.
  assign stall     = id_valid & (w_look_a[2] | w_look_b[2]);
  assign fwd_sel_a = w_look_a[1:0];
  assign fwd_sel_b = w_look_b[1:0];
  assign w_issue   = id_valid & ~stall & ~hold & ~flush;
  assign issue     = w_issue;
  assign pending   = w_valid[NUM_REGS-1:0];

endmodule : pipe_scoreboard
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_scoreboard
//  Description : Self-checking bench for pipe_scoreboard. Two instances share
//                stimulus: u_byp (forwarding) and u_nob (interlock only).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       hold, flush, id_valid, id_use_a, id_use_b, id_wr;
  logic [4:0] id_rs_a, id_rs_b, id_rd;
  logic [1:0] id_kind;

  logic        stall1, iss1, stall0, iss0;
  logic [1:0]  fsa1, fsb1, fsa0, fsb0;
  logic [31:0] pend1, pend0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_scoreboard #(.NUM_REGS(32), .REG_W(5), .BYPASS_EN(1'b1)) u_byp (
    .clock(clk), .reset(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_use_a(id_use_a), .id_rs_b(id_rs_b), .id_use_b(id_use_b),
    .id_rd(id_rd), .id_wr(id_wr), .id_kind(id_kind),
    .stall(stall1), .fwd_sel_a(fsa1), .fwd_sel_b(fsb1), .issue(iss1), .pending(pend1));

  pipe_scoreboard #(.NUM_REGS(32), .REG_W(5), .BYPASS_EN(1'b0)) u_nob (
    .clock(clk), .reset(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_use_a(id_use_a), .id_rs_b(id_rs_b), .id_use_b(id_use_b),
    .id_rd(id_rd), .id_wr(id_wr), .id_kind(id_kind),
    .stall(stall0), .fwd_sel_a(fsa0), .fwd_sel_b(fsb0), .issue(iss0), .pending(pend0));

  // ---------------- reference model ----------------
  // A producer is remembered by the value of a global "advance" count taken
  // when it issued; its age is how many unfrozen cycles have passed since.
  // Index 0 models the interlock-only instance, index 1 the forwarding one.
  int         adv = 0;
  int         stamp [2][32];
  logic [1:0] kindm [2][32];

  typedef struct packed {
    logic       stall;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       issue;
  } exp_t;

  function automatic int m_age(int m, int r);
    int a;
    if (r == 0 || stamp[m][r] < 0) return 0;
    a = adv - stamp[m][r] + 1;
    return (a >= 1 && a <= 3) ? a : 0;
  endfunction

  function automatic logic [2:0] m_op(int m, logic use_op, logic [4:0] rs);
    int a;
    if (!use_op) return 3'b000;
    a = m_age(m, int'(rs));
    if (a == 0) return 3'b000;
    if (m == 0) return 3'b100;
    if (a == 1) return (kindm[m][rs] == 2'd1) ? 3'b100 : 3'b001;
    return (a == 2) ? 3'b010 : 3'b011;
  endfunction

  function automatic exp_t m_out(int m);
    exp_t e;
    logic [2:0] a, b;
    a = m_op(m, id_use_a, id_rs_a);
    b = m_op(m, id_use_b, id_rs_b);
    e.stall = id_valid & (a[2] | b[2]);
    e.sa    = a[1:0];
    e.sb    = b[1:0];
    e.issue = id_valid & ~e.stall & ~hold & ~flush;
    return e;
  endfunction

  function automatic logic [31:0] m_pend(int m);
    logic [31:0] p;
    p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_age(m, r) != 0);
    return p;
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 2; m++)
        for (int r = 0; r < 32; r++) stamp[m][r] <= -1;
    end else begin
      if (!hold) adv <= adv + 1;
      for (int m = 0; m < 2; m++) begin
        if (m_out(m).issue && id_wr && id_rd != 5'd0) begin
          stamp[m][id_rd] <= adv + 1;
          kindm[m][id_rd] <= id_kind;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle;
    hold = 0; flush = 0; id_valid = 0; id_use_a = 0; id_use_b = 0; id_wr = 0;
    id_rs_a = 0; id_rs_b = 0; id_rd = 0; id_kind = 0;
  endtask

  task automatic set_wr(input logic [4:0] rd, input logic [1:0] kind);
    set_idle;
    id_valid = 1; id_wr = 1; id_rd = rd; id_kind = kind;
  endtask

  task automatic do_reset;
    set_idle;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset;
    #1;
    checks++;
    if (stall1 !== 1'b0 || iss1 !== 1'b0 || fsa1 !== 2'd0 || fsb1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b issue=%b sel_a=%0d sel_b=%0d, expected all 0",
               stall1, iss1, fsa1, fsb1);
    end
    checks++;
    if (pend1 !== 32'h0 || pend0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_pending: byp=%h nob=%h, expected 0", pend1, pend0);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_chain;
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    for (int g = 0; g < 4; g++) begin
      do_reset;
      set_wr(5'd3, 2'd0);
      #1;
      checks++;
      if (iss1 !== 1'b1) begin
        errors++;
        $display("FAIL alu_issue gap=%0d: issue=%b, expected 1", g, iss1);
      end
      @(negedge clk);
      set_idle;
      repeat (g) @(negedge clk);
      set_wr(5'd4, 2'd0);
      id_use_a = 1; id_rs_a = 5'd3;
      #1;
      checks++;
      if (stall1 !== 1'b0 || fsa1 !== exp_sel[g]) begin
        errors++;
        $display("FAIL alu_chain gap=%0d: stall=%b sel_a=%0d, expected stall=0 sel_a=%0d",
                 g, stall1, fsa1, exp_sel[g]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use;
    do_reset;
    set_wr(5'd5, 2'd1);
    @(negedge clk);
    set_wr(5'd6, 2'd0);
    id_use_b = 1; id_rs_b = 5'd5;
    #1;
    checks++;
    if (stall1 !== 1'b1 || iss1 !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: stall=%b issue=%b, expected stall=1 issue=0", stall1, iss1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall1 !== 1'b0 || fsb1 !== 2'd2 || iss1 !== 1'b1) begin
      errors++;
      $display("FAIL load_use_release: stall=%b sel_b=%0d issue=%b, expected 0/2/1",
               stall1, fsb1, iss1);
    end
    @(negedge clk);
  endtask

  task automatic test_muldiv;
    do_reset;
    set_wr(5'd7, 2'd2);
    @(negedge clk);
    set_wr(5'd8, 2'd0);
    id_use_a = 1; id_rs_a = 5'd7; hold = 1;
    for (int c = 0; c < 33; c++) begin
      #1;
      checks++;
      if (pend1[7] !== 1'b1 || fsa1 !== 2'd1 || iss1 !== 1'b0 || stall1 !== 1'b0) begin
        errors++;
        $display("FAIL muldiv_hold cyc=%0d: pend7=%b sel_a=%0d issue=%b stall=%b, expected 1/1/0/0",
                 c, pend1[7], fsa1, iss1, stall1);
      end
      @(negedge clk);
    end
    hold = 0;
    #1;
    checks++;
    if (fsa1 !== 2'd1 || iss1 !== 1'b1) begin
      errors++;
      $display("FAIL muldiv_release: sel_a=%0d issue=%b, expected sel_a=1 issue=1", fsa1, iss1);
    end
    @(negedge clk);
  endtask

  task automatic test_overwrite;
    do_reset;
    set_wr(5'd2, 2'd0);
    @(negedge clk);
    set_wr(5'd2, 2'd0);
    @(negedge clk);
    set_idle;
    id_valid = 1; id_use_a = 1; id_rs_a = 5'd2;
    #1;
    checks++;
    if (fsa1 !== 2'd1 || pend1 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL overwrite_newest: sel_a=%0d pending=%h, expected sel_a=1 pending=00000004",
               fsa1, pend1);
    end
    @(negedge clk);
    do_reset;
    set_wr(5'd0, 2'd0);
    @(negedge clk);
    set_idle;
    #1;
    checks++;
    if (pend1 !== 32'h0) begin
      errors++;
      $display("FAIL rd_zero: pending=%h, expected 0", pend1);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass_off;
    do_reset;
    set_wr(5'd3, 2'd0);
    @(negedge clk);
    set_idle;
    id_valid = 1; id_use_a = 1; id_rs_a = 5'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (stall0 !== 1'b1 || iss0 !== 1'b0) begin
        errors++;
        $display("FAIL nobypass_stall cyc=%0d: stall=%b issue=%b, expected 1/0", c, stall0, iss0);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (stall0 !== 1'b0 || fsa0 !== 2'd0 || iss0 !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_release: stall=%b sel_a=%0d issue=%b, expected 0/0/1",
               stall0, fsa0, iss0);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_reset;
    do_reset;
    set_wr(5'd9, 2'd0);
    flush = 1;
    #1;
    checks++;
    if (iss1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue: issue=%b, expected 0", iss1);
    end
    @(negedge clk);
    set_idle;
    #1;
    checks++;
    if (pend1[9] !== 1'b0) begin
      errors++;
      $display("FAIL flush_pending: pending[9]=%b, expected 0", pend1[9]);
    end
    @(negedge clk);
    set_wr(5'd1, 2'd0); @(negedge clk);
    set_wr(5'd2, 2'd1); @(negedge clk);
    set_wr(5'd3, 2'd2);
    #1;
    checks++;
    if (pend1 !== 32'h0000_0006) begin
      errors++;
      $display("FAIL pre_reset_pending: pending=%h, expected 00000006", pend1);
    end
    @(negedge clk);
    set_idle;
    #1;
    checks++;
    if (pend1 !== 32'h0000_000E) begin
      errors++;
      $display("FAIL three_pending: pending=%h, expected 0000000e", pend1);
    end
    rst = 1; hold = 1; flush = 1;
    @(negedge clk);
    rst = 0; set_idle;
    #1;
    checks++;
    if (pend1 !== 32'h0 || pend0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: byp=%h nob=%h, expected 0", pend1, pend0);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    exp_t        e1, e0;
    logic [31:0] p1, p0;
    do_reset;
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      hold     = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 9) < 8);
      id_use_a = ($urandom_range(0, 3) != 0);
      id_use_b = ($urandom_range(0, 1) != 0);
      id_wr    = ($urandom_range(0, 4) != 0);
      id_rs_a  = 5'($urandom_range(0, 7));
      id_rs_b  = 5'($urandom_range(0, 7));
      id_rd    = 5'($urandom_range(0, 7));
      id_kind  = 2'($urandom_range(0, 3));
      #1;
      e1 = m_out(1); e0 = m_out(0);
      p1 = m_pend(1); p0 = m_pend(0);
      checks++;
      if ({stall1, fsa1, fsb1, iss1} !== e1) begin
        errors++;
        $display("FAIL rand_byp i=%0d: stall/sa/sb/issue=%b/%0d/%0d/%b, expected %b/%0d/%0d/%b",
                 i, stall1, fsa1, fsb1, iss1, e1.stall, e1.sa, e1.sb, e1.issue);
      end
      checks++;
      if ({stall0, fsa0, fsb0, iss0} !== e0) begin
        errors++;
        $display("FAIL rand_nob i=%0d: stall/sa/sb/issue=%b/%0d/%0d/%b, expected %b/%0d/%0d/%b",
                 i, stall0, fsa0, fsb0, iss0, e0.stall, e0.sa, e0.sb, e0.issue);
      end
      checks++;
      if (pend1 !== p1 || pend0 !== p0) begin
        errors++;
        $display("FAIL rand_pending i=%0d: byp=%h nob=%h, expected byp=%h nob=%h",
                 i, pend1, pend0, p1, p0);
      end
      @(negedge clk);
    end
    rst = 0;
    set_idle;
  endtask

  initial begin
    set_idle;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    test_reset;
    test_alu_chain;
    test_load_use;
    test_muldiv;
    test_overwrite;
    test_bypass_off;
    test_flush_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_scoreboard
`default_nettype wire
